// File: rtl/riscv_hazard_ctrl.sv
// Hazard and sequencing controller for the execute stage of a 5-stage RV32I pipeline.
// Produces forwarding selects, load-use stalls, branch/jump flushes, and runs an
// iterative multi-cycle execute unit through a start/done handshake guarded by a watchdog.
//
// Handshake with the multi-cycle unit: o_McStart is a single-cycle request issued
// only from IDLE. i_McDone is a single-cycle completion pulse and only counts while
// BUSY, so a stray pulse in IDLE is ignored. The unit may raise i_McDone no earlier
// than the cycle after o_McStart. If the watchdog saturates first, o_McTimeout pulses
// and the controller gives up, releasing the pipeline.
module riscv_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int WDT_W  = 6
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [REG_AW-1:0] i_Rs1D,
   input  logic [REG_AW-1:0] i_Rs2D,
   input  logic [REG_AW-1:0] i_Rs1E,
   input  logic [REG_AW-1:0] i_Rs2E,
   input  logic [REG_AW-1:0] i_RdE,
   input  logic              i_LoadE,
   input  logic              i_PCSrcE,
   input  logic [REG_AW-1:0] i_RdM,
   input  logic              i_RegWriteM,
   input  logic [REG_AW-1:0] i_RdW,
   input  logic              i_RegWriteW,
   input  logic              i_McReqE,
   input  logic              i_McDone,
   output logic [1:0]        o_ForwardAE,
   output logic [1:0]        o_ForwardBE,
   output logic              o_StallF,
   output logic              o_StallD,
   output logic              o_StallE,
   output logic              o_FlushD,
   output logic              o_FlushE,
   output logic              o_FlushM,
   output logic              o_McStart,
   output logic              o_McBusy,
   output logic              o_McTimeout
);

   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       BUSY    = 1'b1;
   localparam logic [WDT_W-1:0] WDT_MAX = '1;
   localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

   logic             runQ0;
   logic             rRun;
   logic [0:0]       state;
   logic [0:0]       stateNxt;
   logic [WDT_W-1:0] wdt;
   logic [WDT_W-1:0] wdtNxt;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;
   logic             lwStall;
   logic             stallF;
   logic             stallD;
   logic             stallE;
   logic             flushD;
   logic             flushE;
   logic             flushM;
   logic             mcStart;
   logic             mcTimeout;

   // Two-flop run qualifier: pipeline is held flushed until the 2nd edge after reset release.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         runQ0 <= 1'b0;
         rRun  <= 1'b0;
      end else begin
         runQ0 <= 1'b1;
         rRun  <= runQ0;
      end
   end

   // Forwarding selects (M beats W, x0 never forwarded) and load-use detection.
   always_comb begin
      fwdA = 2'b00;
      fwdB = 2'b00;
      if (i_RegWriteM && (i_RdM != '0) && (i_RdM == i_Rs1E))
         fwdA = 2'b10;
      else if (i_RegWriteW && (i_RdW != '0) && (i_RdW == i_Rs1E))
         fwdA = 2'b01;
      if (i_RegWriteM && (i_RdM != '0) && (i_RdM == i_Rs2E))
         fwdB = 2'b10;
      else if (i_RegWriteW && (i_RdW != '0) && (i_RdW == i_Rs2E))
         fwdB = 2'b01;
      lwStall = i_LoadE && (i_RdE != '0) && ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
   end

   // Sequencing: multi-cycle FSM first, then control-transfer flush, then load-use stall.
   always_comb begin
      stateNxt  = state;
      wdtNxt    = wdt;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      mcStart   = 1'b0;
      mcTimeout = 1'b0;
      if (!rRun) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (i_PCSrcE) begin
                  // Taken branch/jump squashes younger instructions, including a
                  // wrong-path multi-cycle request or load-use hazard.
                  flushD = 1'b1;
                  flushE = 1'b1;
               end else if (i_McReqE) begin
                  mcStart  = 1'b1;
                  stateNxt = BUSY;
                  wdtNxt   = '0;
                  stallF   = 1'b1;
                  stallD   = 1'b1;
                  stallE   = 1'b1;
                  flushM   = 1'b1;
               end else if (lwStall) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
               end
            end
            default: begin
               if (i_McDone) begin
                  // Result advances into M at this edge.
                  stateNxt = IDLE;
               end else if (wdt == WDT_MAX) begin
                  mcTimeout = 1'b1;
                  stateNxt  = IDLE;
               end else begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  stallE = 1'b1;
                  flushM = 1'b1;
                  wdtNxt = wdt + WDT_ONE;
               end
            end
         endcase
      end
   end

   // FSM state and watchdog registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= IDLE;
         wdt   <= '0;
      end else begin
         state <= stateNxt;
         wdt   <= wdtNxt;
      end
   end

   // Outputs: everything except the reset-time flushes is qualified by rRun.
   always_comb begin
      o_ForwardAE = rRun ? fwdA : 2'b00;
      o_ForwardBE = rRun ? fwdB : 2'b00;
      o_StallF    = stallF;
      o_StallD    = stallD;
      o_StallE    = stallE;
      o_FlushD    = flushD;
      o_FlushE    = flushE;
      o_FlushM    = flushM;
      o_McStart   = mcStart;
      o_McBusy    = rRun && (state == BUSY);
      o_McTimeout = mcTimeout;
   end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed-vector bench for riscv_hazard_ctrl (watchdog shortened to WDT_W=3).
// Control outputs are compared as one 9-bit word:
// {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart, McBusy, McTimeout}.
module tb_riscv_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int WDT_W  = 3;

   localparam logic [8:0] C_IDLE  = 9'b000_000_000;
   localparam logic [8:0] C_FLUSH = 9'b000_110_000;
   localparam logic [8:0] C_LWST  = 9'b110_010_000;
   localparam logic [8:0] C_START = 9'b111_001_100;
   localparam logic [8:0] C_BUSY  = 9'b111_001_010;
   localparam logic [8:0] C_DONE  = 9'b000_000_010;
   localparam logic [8:0] C_TMO   = 9'b000_000_011;

   logic              clk;
   logic              rstn;
   logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic              loadE, pcSrcE, regWriteM, regWriteW, mcReqE, mcDone;
   logic [1:0]        fwdA, fwdB;
   logic              stallF, stallD, stallE, flushD, flushE, flushM;
   logic              mcStart, mcBusy, mcTimeout;
   logic [8:0]        ctl;

   int                nChecks = 0;
   int                nPass   = 0;

   riscv_hazard_ctrl #(.REG_AW(REG_AW), .WDT_W(WDT_W)) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_Rs1D      (rs1D),
      .i_Rs2D      (rs2D),
      .i_Rs1E      (rs1E),
      .i_Rs2E      (rs2E),
      .i_RdE       (rdE),
      .i_LoadE     (loadE),
      .i_PCSrcE    (pcSrcE),
      .i_RdM       (rdM),
      .i_RegWriteM (regWriteM),
      .i_RdW       (rdW),
      .i_RegWriteW (regWriteW),
      .i_McReqE    (mcReqE),
      .i_McDone    (mcDone),
      .o_ForwardAE (fwdA),
      .o_ForwardBE (fwdB),
      .o_StallF    (stallF),
      .o_StallD    (stallD),
      .o_StallE    (stallE),
      .o_FlushD    (flushD),
      .o_FlushE    (flushE),
      .o_FlushM    (flushM),
      .o_McStart   (mcStart),
      .o_McBusy    (mcBusy),
      .o_McTimeout (mcTimeout)
   );

   assign ctl = {stallF, stallD, stallE, flushD, flushE, flushM, mcStart, mcBusy, mcTimeout};

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic setIdle();
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
      rdE = '0; rdM = '0; rdW = '0;
      loadE = 1'b0; pcSrcE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
      mcReqE = 1'b0; mcDone = 1'b0;
   endtask

   // Advance past a rising edge; inputs are then changed and outputs sampled mid-cycle.
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      setIdle();
      rstn = 1'b0;

      // Reset: flush D/E only, even with a forwarding match present.
      rs1E = 5'd5; rdM = 5'd5; regWriteM = 1'b1;
      #3;
      check("rst_ctl", 32'(ctl), 32'(C_FLUSH));
      check("rst_fwdA", 32'(fwdA), 32'd0);
      setIdle();

      // Release between edges; r_run rises on the 2nd edge.
      #9 rstn = 1'b1;
      nextCycle();
      check("run0_ctl", 32'(ctl), 32'(C_FLUSH));
      nextCycle();
      check("run1_ctl", 32'(ctl), 32'(C_IDLE));

      // Forwarding.
      rs1E = 5'd5; rdM = 5'd5; regWriteM = 1'b1; rdW = 5'd5; regWriteW = 1'b1;
      #1 check("fwdA_M", 32'(fwdA), 32'd2);
      check("fwdB_none", 32'(fwdB), 32'd0);
      regWriteM = 1'b0;
      #1 check("fwdA_W", 32'(fwdA), 32'd1);
      rs1E = 5'd0; rdM = 5'd0; regWriteM = 1'b1; rdW = 5'd0;
      #1 check("fwdA_x0", 32'(fwdA), 32'd0);
      rs2E = 5'd7; rdM = 5'd7; regWriteM = 1'b0; rdW = 5'd7; regWriteW = 1'b1;
      #1 check("fwdB_W", 32'(fwdB), 32'd1);
      regWriteM = 1'b1;
      #1 check("fwdB_M", 32'(fwdB), 32'd2);
      check("fwd_ctl", 32'(ctl), 32'(C_IDLE));
      setIdle();

      // Load-use hazard for one cycle, then the bubble moves on.
      nextCycle();
      loadE = 1'b1; rdE = 5'd3; rs2D = 5'd3;
      #1 check("lw_ctl", 32'(ctl), 32'(C_LWST));
      pcSrcE = 1'b1;
      #1 check("lw_pcsrc", 32'(ctl), 32'(C_FLUSH));
      pcSrcE = 1'b0; rdE = 5'd0; rs2D = 5'd0;
      #1 check("lw_x0", 32'(ctl), 32'(C_IDLE));
      nextCycle();
      setIdle();
      #1 check("lw_after", 32'(ctl), 32'(C_IDLE));

      // Multi-cycle: start + 3 busy stalls, done in the 5th cycle.
      nextCycle();
      mcReqE = 1'b1;
      #1 check("mc_start", 32'(ctl), 32'(C_START));
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         check($sformatf("mc_busy%0d", i), 32'(ctl), 32'(C_BUSY));
      end
      nextCycle();
      mcDone = 1'b1;
      #1 check("mc_done", 32'(ctl), 32'(C_DONE));
      nextCycle();
      mcDone = 1'b0; mcReqE = 1'b0;
      #1 check("mc_idle", 32'(ctl), 32'(C_IDLE));

      // Request together with a taken branch: branch wins, no start.
      mcReqE = 1'b1; pcSrcE = 1'b1;
      #1 check("mc_pcsrc", 32'(ctl), 32'(C_FLUSH));
      nextCycle();
      mcReqE = 1'b0; pcSrcE = 1'b0;
      #1 check("mc_pcsrc_after", 32'(ctl), 32'(C_IDLE));

      // Watchdog: 7 busy stall cycles, then timeout.
      mcReqE = 1'b1;
      #1 check("wdt_start", 32'(ctl), 32'(C_START));
      for (int i = 0; i < 7; i++) begin
         nextCycle();
         check($sformatf("wdt_busy%0d", i), 32'(ctl), 32'(C_BUSY));
      end
      nextCycle();
      check("wdt_timeout", 32'(ctl), 32'(C_TMO));
      nextCycle();
      mcReqE = 1'b0;
      #1 check("wdt_idle", 32'(ctl), 32'(C_IDLE));

      // Async reset in the 2nd busy cycle.
      mcReqE = 1'b1;
      #1 check("ar_start", 32'(ctl), 32'(C_START));
      nextCycle();
      nextCycle();
      check("ar_busy2", 32'(ctl), 32'(C_BUSY));
      rstn = 1'b0;
      #1 check("ar_inreset", 32'(ctl), 32'(C_FLUSH));
      setIdle();
      #1 rstn = 1'b1;
      nextCycle();
      nextCycle();
      check("ar_released", 32'(ctl), 32'(C_IDLE));
      mcDone = 1'b1;
      #1 check("ar_stray_done", 32'(ctl), 32'(C_IDLE));
      nextCycle();
      mcDone = 1'b0;
      #1 check("ar_stray_after", 32'(ctl), 32'(C_IDLE));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
